pll_lock_supervisor: RTL and testbench

// - Consumes the PLL LOCK output. Runs in the PLL output clock domain.
// - Synchronises the lock flag and requires it to be continuously stable before releasing the

---
 rtl/pll_supervisor_pkg.sv | 15 +
 rtl/pll_lock_supervisor_sync_ff.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 121 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
// Shared types and defaults for the PLL lock supervisor and its helpers.
package pll_supervisor_pkg;

    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
    localparam int unsigned DEFAULT_STABLE_CYCLES = 1024;
    localparam int unsigned DEFAULT_CNT_W         = 8;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        STABLE = 2'd1,
        RUN    = 2'd2,
        LOST   = 2'd3
    } state_e;

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; async active-low clear.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock, releases the design reset after a stable window and reports lock loss.
// PLL_SUPERVISOR_LOSS_COUNTER_EN enables the saturating loss_count counter (tied to 0 otherwise).
module pll_lock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_locked,
    output logic             sys_reset_n,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count
);

    localparam int unsigned SC_W = $clog2(STABLE_CYCLES);
    localparam logic [SC_W-1:0] SC_TERM = SC_W'(STABLE_CYCLES - 1);

    logic            locked_s;
    state_e          state_q, state_d;
    logic [SC_W-1:0] stable_cnt_q, stable_cnt_d;
    logic            sys_reset_n_q, sys_reset_n_d;
    logic            ready_q, ready_d;
    logic            lock_lost_q, lock_lost_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // Terminal compare precedes the increment, so stable_cnt never wraps.
    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        unique case (state_q)
            WAIT: begin
                stable_cnt_d = '0;
                if (locked_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    stable_cnt_d = '0;
                    state_d      = WAIT;
                end else if (stable_cnt_q == SC_TERM) begin
                    state_d = RUN;
                end else begin
                    stable_cnt_d = stable_cnt_q + SC_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                state_d = WAIT;
            end
            default: begin
                state_d = WAIT;
            end
        endcase

        sys_reset_n_d = (state_d == RUN);
        ready_d       = (state_d == RUN);
        lock_lost_d   = (state_d == LOST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT;
            stable_cnt_q  <= '0;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            stable_cnt_q  <= stable_cnt_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign lock_lost   = lock_lost_q;

`ifdef PLL_SUPERVISOR_LOSS_COUNTER_EN
    logic [CNT_W-1:0] loss_count_q, loss_count_d;

    // Count each entry into LOST, holding at all-ones.
    always_comb begin
        loss_count_d = loss_count_q;
        if ((state_d == LOST) && (loss_count_q != '1)) begin
            loss_count_d = loss_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_count_q <= '0;
        end else begin
            loss_count_q <= loss_count_d;
        end
    end

    assign loss_count = loss_count_q;
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor (SYNC_STAGES=2, STABLE_CYCLES=8, CNT_W=2).
module tb_pll_lock_supervisor;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned STABLE_CYCLES = 8;
    localparam int unsigned CNT_W         = 2;
    localparam int          RELEASE_EDGES = 11;
    localparam int          WAIT_BUDGET   = 40;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             pll_locked;
    logic             sys_reset_n;
    logic             ready;
    logic             lock_lost;
    logic [CNT_W-1:0] loss_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .loss_count  (loss_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n active edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges until sys_reset_n rises (bounded), plus lock_lost pulses seen meanwhile.
    task automatic wait_release(output int edges, output int pulses);
        edges  = 0;
        pulses = 0;
        while (edges < WAIT_BUDGET) begin
            tick(1);
            edges++;
            if (lock_lost) pulses++;
            if (sys_reset_n) break;
        end
    endtask

    function automatic int exp_loss(input int k);
`ifdef PLL_SUPERVISOR_LOSS_COUNTER_EN
        return (k > 3) ? 3 : k;
`else
        return 0;
`endif
    endfunction

    int edges;
    int pulses;
    int n_pulses;

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b1;

        // 1: reset holds all outputs low even with lock present
        tick(3);
        check("rst_sys_reset_n", 32'(sys_reset_n), 0);
        check("rst_ready",       32'(ready),       0);
        check("rst_lock_lost",   32'(lock_lost),   0);
        check("rst_loss_count",  32'(loss_count),  0);
        reset_n = 1'b1;
        wait_release(edges, pulses);
        check("t1_release_edges", 32'(edges), 32'(RELEASE_EDGES));
        check("t1_ready",         32'(ready), 1);

        // 2: one-cycle glitch at stable_cnt=5 restarts the window
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        pll_locked = 1'b1;
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        check("t2_state_wait",   32'(dut.state_q), 0);
        check("t2_sysrst_low",   32'(sys_reset_n), 0);
        begin
            int e2, p2;
            wait_release(e2, p2);
            check("t2_release_edges", 32'(e2 + 2), 32'(RELEASE_EDGES));
            check("t2_no_lock_lost",  32'(p2), 0);
        end

        // 3: lock loss in RUN
        pll_locked = 1'b0;
        tick(2);
        check("t3_sysrst_still_hi", 32'(sys_reset_n), 1);
        tick(1);
        check("t3_sysrst_low",  32'(sys_reset_n), 0);
        check("t3_ready_low",   32'(ready),       0);
        check("t3_lock_lost",   32'(lock_lost),   1);
        check("t3_loss_count",  32'(loss_count),  32'(exp_loss(1)));
        tick(1);
        check("t3_lock_lost_end", 32'(lock_lost), 0);
        pll_locked = 1'b1;
        wait_release(edges, pulses);
        check("t3_relock_edges", 32'(edges), 32'(RELEASE_EDGES));

        // 4: five loss cycles from a clean reset; counter saturates at 3
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        wait_release(edges, pulses);
        check("t4_initial_release", 32'(edges), 32'(RELEASE_EDGES));
        n_pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            pll_locked = 1'b0;
            tick(3);
            if (lock_lost) n_pulses++;
            check($sformatf("t4_loss_count_%0d", k), 32'(loss_count), 32'(exp_loss(k)));
            tick(1);
            pll_locked = 1'b1;
            wait_release(edges, pulses);
            check($sformatf("t4_release_%0d", k), 32'(edges), 32'(RELEASE_EDGES));
        end
        check("t4_pulses",        32'(n_pulses),   5);
        tick(5);
        check("t4_loss_count_hold", 32'(loss_count), 32'(exp_loss(5)));

        // 5: async reset between edges while in RUN
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_sysrst_async", 32'(sys_reset_n),   0);
        check("t5_ready",        32'(ready),         0);
        check("t5_loss_count",   32'(loss_count),    0);
        check("t5_state",        32'(dut.state_q),   0);

        // 6: locked_s drops on the terminal stable_cnt edge
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(8);
        pll_locked = 1'b0;
        tick(2);
        check("t6_cnt_terminal", 32'(dut.stable_cnt_q), 7);
        check("t6_state_stable", 32'(dut.state_q),      1);
        tick(1);
        check("t6_state_wait",   32'(dut.state_q), 0);
        check("t6_sysrst_low",   32'(sys_reset_n), 0);
        check("t6_ready_low",    32'(ready),       0);
        check("t6_no_lock_lost", 32'(lock_lost),   0);
        tick(1);
        check("t6_sysrst_stays", 32'(sys_reset_n), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
